// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and the
// byte/word geometry of the instruction stream.
package boot_pkg;

    // Bytes per instruction word, shifted in little-endian order.
    localparam int BYTE_LANES = 4;
    localparam int LANE_W     = $clog2(BYTE_LANES);

    // Width constants, independent of instruction encoding.
    localparam int BYTE_W  = 8;
    localparam int INSTR_W = BYTE_LANES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } boot_state_t;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Byte-to-word assembler: shifts accepted bytes in little-endian order and
// flags the byte that completes a word so the FSM can schedule the write.
module word_assembler
    import boot_pkg::*;
#(
    parameter int WORD_W = INSTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    logic [LANE_W-1:0] lane;

    // The byte being accepted now is the last lane of the current word.
    assign full = byte_vld && (lane == LANE_W'(BYTE_LANES - 1));

    // New bytes enter at the top so byte 0 ends up in bits [7:0] after four shifts.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            lane <= '0;
            word <= '0;
        end else if (byte_vld) begin
            lane <= lane + LANE_W'(1);
            word <= {byte_in, word[WORD_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a length byte followed by little-endian instruction
// bytes, writes each word into instruction memory and holds the core in
// reset until the image is complete.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing XOR
// checksum byte before the core is released.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // One extra bit so a full memory (N == 2^ADDR_W) is representable.
    localparam int LEN_W = ADDR_W + 1;
    localparam int WORDS = 2 ** ADDR_W;

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t ST_FINAL = ST_CSUM;
    logic [7:0] csum;
`else
    localparam boot_state_t ST_FINAL = ST_DONE;
`endif

    boot_state_t      state;
    boot_state_t      nxt;
    logic             acc;
    logic             clr;
    logic             asm_vld;
    logic             asm_full;
    logic             last_word;
    logic [LEN_W-1:0] wcnt;
    logic [LEN_W-1:0] wcnt_inc;
    logic [LEN_W-1:0] len;

    assign acc       = rx_valid && rx_ready;
    assign clr       = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign asm_vld   = acc && (state == ST_LOAD);
    assign wcnt_inc  = wcnt + LEN_W'(1);
    assign last_word = (wcnt_inc == len);

    word_assembler #(
        .WORD_W (WORD_W)
    ) u_asm (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .byte_vld (asm_vld),
        .byte_in  (rx_data),
        .word     (im_wdata),
        .full     (asm_full)
    );

    // Next-state decode; start is only honoured from IDLE, DONE and ERROR.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) nxt = ST_LEN;
            end
            ST_LEN: begin
                if (acc) begin
                    if (int'(rx_data) > WORDS) nxt = ST_ERROR;
                    else if (rx_data == 8'd0)  nxt = ST_FINAL;
                    else                       nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (asm_full) nxt = ST_WRITE;
            end
            ST_WRITE: begin
                nxt = last_word ? ST_FINAL : ST_LOAD;
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (acc) nxt = (rx_data == csum) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (start) nxt = ST_LEN;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // State, registered outputs (decoded from the next state) and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            wcnt      <= '0;
            len       <= '0;
        end else begin
            state     <= nxt;
            rx_ready  <= (nxt == ST_LEN) || (nxt == ST_LOAD) || (nxt == ST_CSUM);
            im_we     <= (nxt == ST_WRITE);
            cpu_reset <= (nxt != ST_DONE);
            done      <= (nxt == ST_DONE);
            error     <= (nxt == ST_ERROR);

            if (clr) begin
                wcnt    <= '0;
                len     <= '0;
                im_addr <= '0;
            end
            if (state == ST_LEN && acc) len <= LEN_W'(rx_data);
            if (nxt == ST_WRITE) im_addr <= wcnt[ADDR_W-1:0];
            if (state == ST_WRITE) wcnt <= wcnt_inc;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running XOR over data bytes only; the length byte is excluded.
    always_ff @(posedge clk) begin
        if (reset || clr) csum <= 8'd0;
        else if (asm_vld) csum <= csum ^ rx_data;
    end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader. Works with or without BOOT_CHECKSUM_EN;
// when enabled, each image is terminated with its checksum byte.
module tb_boot_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_we;
    logic [4:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // write monitor
    logic [4:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_n = 0;

    boot_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = im_addr;
                wr_data[wr_n] = im_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte=%h rx_ready=%b required 1", b, rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle_gap();
        rx_valid = 1'b0;
        rx_data  = 8'hEE;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // After the last data word: checksum byte if enabled, else one cycle.
    task automatic finish_image(input logic [7:0] cs);
`ifdef BOOT_CHECKSUM_EN
        send_byte(cs);
`else
        rx_data = cs;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        checks++;
        if ({cpu_reset, rx_ready, im_we, done, error, im_addr, im_wdata} !== {5'b10000, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_values got cr=%b rdy=%b we=%b done=%b err=%b addr=%h data=%h required 1 0 0 0 0 00 00000000",
                     cpu_reset, rx_ready, im_we, done, error, im_addr, im_wdata);
        end
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_reset, rx_ready, im_we, done, error} !== 5'b10000) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d got cr=%b rdy=%b we=%b done=%b err=%b required 1 0 0 0 0",
                         i, cpu_reset, rx_ready, im_we, done, error);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_stream();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        checks++;
        if ({im_we, im_addr, im_wdata} !== {1'b1, 5'd0, 32'h00500093}) begin
            errors++;
            $display("FAIL stream_write0 got we=%b addr=%h data=%h required 1 00 00500093", im_we, im_addr, im_wdata);
        end
        send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0); send_byte(8'h00);
        checks++;
        if ({im_we, im_addr, im_wdata, done} !== {1'b1, 5'd1, 32'h00A00113, 1'b0}) begin
            errors++;
            $display("FAIL stream_write1 got we=%b addr=%h data=%h done=%b required 1 01 00a00113 0",
                     im_we, im_addr, im_wdata, done);
        end
        finish_image(8'h71);
        checks++;
        if ({done, cpu_reset, error} !== 3'b100) begin
            errors++;
            $display("FAIL stream_release got done=%b cr=%b err=%b required 1 0 0", done, cpu_reset, error);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ((wr_n - base) !== 2) begin
            errors++;
            $display("FAIL stream_we_count got %0d required 2", wr_n - base);
        end
        checks++;
        if ({done, cpu_reset} !== 2'b10) begin
            errors++;
            $display("FAIL stream_done_held got done=%b cr=%b required 1 0", done, cpu_reset);
        end
    endtask

    task automatic test_toggle();
        int base;
        logic [7:0] img [8];
        img[0] = 8'h93; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h00;
        img[4] = 8'h13; img[5] = 8'h01; img[6] = 8'hA0; img[7] = 8'h00;
        base = wr_n;
        pulse_start();
        checks++;
        if ({done, cpu_reset, error, rx_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL restart_from_done got done=%b cr=%b err=%b rdy=%b required 0 1 0 1",
                     done, cpu_reset, error, rx_ready);
        end
        send_byte(8'h02);
        idle_gap();
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i]);
            idle_gap();
        end
        finish_image(8'h71);
        repeat (2) @(negedge clk);
        checks++;
        if ((wr_n - base) !== 2) begin
            errors++;
            $display("FAIL toggle_we_count got %0d required 2", wr_n - base);
        end
        checks++;
        if ({wr_addr[base], wr_data[base]} !== {5'd0, 32'h00500093}) begin
            errors++;
            $display("FAIL toggle_write0 got addr=%h data=%h required 00 00500093", wr_addr[base], wr_data[base]);
        end
        checks++;
        if ({wr_addr[base+1], wr_data[base+1]} !== {5'd1, 32'h00A00113}) begin
            errors++;
            $display("FAIL toggle_write1 got addr=%h data=%h required 01 00a00113", wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if ({done, cpu_reset} !== 2'b10) begin
            errors++;
            $display("FAIL toggle_done got done=%b cr=%b required 1 0", done, cpu_reset);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'd33);
        checks++;
        if ({error, cpu_reset, done, rx_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL overflow_error got err=%b cr=%b done=%b rdy=%b required 1 1 0 0",
                     error, cpu_reset, done, rx_ready);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ((wr_n - base) !== 0 || error !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold got writes=%0d err=%b cr=%b required 0 1 1", wr_n - base, error, cpu_reset);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL overflow_restart got err=%b required 0", error);
        end
        send_byte(8'd1);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        finish_image(8'h16);
        checks++;
        if ((wr_n - base) !== 1 || wr_addr[base] !== 5'd0 || wr_data[base] !== 32'h00000513) begin
            errors++;
            $display("FAIL overflow_recover got writes=%0d addr=%h data=%h required 1 00 00000513",
                     wr_n - base, wr_addr[base], wr_data[base]);
        end
        checks++;
        if ({done, cpu_reset, error} !== 3'b100) begin
            errors++;
            $display("FAIL overflow_recover_done got done=%b cr=%b err=%b required 1 0 0", done, cpu_reset, error);
        end
    endtask

    task automatic test_reset_midload();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'd3);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({cpu_reset, rx_ready, im_we, done, error, im_addr, im_wdata} !== {5'b10000, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL midload_reset_values got cr=%b rdy=%b we=%b done=%b err=%b addr=%h data=%h required 1 0 0 0 0 00 00000000",
                     cpu_reset, rx_ready, im_we, done, error, im_addr, im_wdata);
        end
        checks++;
        if ((wr_n - base) !== 1 || wr_addr[base] !== 5'd0 || wr_data[base] !== 32'h00500093) begin
            errors++;
            $display("FAIL midload_writes got writes=%0d addr=%h data=%h required 1 00 00500093",
                     wr_n - base, wr_addr[base], wr_data[base]);
        end
        base = wr_n;
        pulse_start();
        send_byte(8'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        finish_image(8'h00);
        checks++;
        if ((wr_n - base) !== 1 || wr_addr[base] !== 5'd0 || wr_data[base] !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL midload_reload got writes=%0d addr=%h data=%h required 1 00 ddccbbaa",
                     wr_n - base, wr_addr[base], wr_data[base]);
        end
        checks++;
        if ({done, cpu_reset} !== 2'b10) begin
            errors++;
            $display("FAIL midload_reload_done got done=%b cr=%b required 1 0", done, cpu_reset);
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_byte(8'hC3);
        checks++;
        if ({done, error, cpu_reset} !== 3'b100) begin
            errors++;
            $display("FAIL csum_good got done=%b err=%b cr=%b required 1 0 0", done, error, cpu_reset);
        end
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_byte(8'hC2);
        checks++;
        if ({done, error, cpu_reset} !== 3'b011) begin
            errors++;
            $display("FAIL csum_bad got done=%b err=%b cr=%b required 0 1 1", done, error, cpu_reset);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_overflow();
        test_reset_midload();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream loader for the single-cycle RISC-V core.
- Accepts a byte stream, assembles little-endian 32-bit instructions, and writes them into instruction memory through a write port.
- Holds the processor in reset while loading and releases it when the image is complete.
- Sits between a byte source (UART receiver or bench driver) and the processor's instruction memory and `reset` input.

Parameters:
- ADDR_W, 5, instruction-memory word-address width; capacity is 2^ADDR_W words (32).
- WORD_W, 32, instruction width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load.
- rx_valid  input  1  source has a byte on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write enable, one-cycle pulse.
- im_addr  output  ADDR_W  word address for the write.
- im_wdata  output  WORD_W  assembled instruction.
- cpu_reset  output  1  drives the processor `reset`; high = held.
- done  output  1  image loaded, core running.
- error  output  1  load aborted.

Behaviour:
- Reset values:
  - rx_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - State=IDLE; byte counter=0, word counter=0, length=0.
- Handshake: a byte transfers when rx_valid && rx_ready at a clock edge. rx_ready is registered and is high only in LEN, LOAD and CSUM.
- States:
  - IDLE: cpu_reset=1. start -> LEN.
  - LEN: accept one byte N (number of words).
    - N > 2^ADDR_W -> ERROR.
    - N == 0 -> CSUM if enabled, else DONE.
    - Otherwise -> LOAD.
  - LOAD: accept bytes in little-endian order.
    - byte 0 -> [7:0], byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24].
    - On the 4th byte -> WRITE.
  - WRITE: rx_ready=0 for exactly one cycle.
    - im_we=1, im_addr=word counter, im_wdata=assembled word.
    - Then the word counter increments.
    - If word counter+1 == N -> CSUM (feature on) or DONE; else -> LOAD.
  - DONE: cpu_reset=0, done=1; both held.
  - ERROR: error=1, cpu_reset=1; both held.
- Latency:
  - 4th byte accepted at edge t -> im_we high during cycle t+1.
  - Final write cycle at edge t -> cpu_reset low and done high from edge t+1.
- Word counter: ADDR_W+1 bits. The final write, at 2^ADDR_W-1, does not wrap the address.
- start is ignored in LEN/LOAD/WRITE/CSUM. In DONE or ERROR, start re-enters LEN:
  - cpu_reset=1, done=0, error=0 from the next edge.
  - Counters cleared.
- Reset mid-load:
  - Returns to reset values at the next edge; the partial word is discarded.
  - Words already written stay in memory. No im_we is issued during reset.
- rx_valid outside the accepting states is ignored and no byte is consumed.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- When defined:
  - A running XOR of every data byte (not the length byte) is kept.
  - CSUM state accepts one byte: equal to the running XOR -> DONE; otherwise -> ERROR.
  - For N=0 the expected byte is 0x00.
- When undefined: no CSUM state, no checksum register; the transition after the last write goes directly to DONE.

Decomposition:
- Shared package `boot_pkg`:
  - State enum: IDLE, LEN, LOAD, WRITE, CSUM, DONE, ERROR.
  - Byte-lane constant 4.
  - Opcode-agnostic width constants.
- Sub-module `word_assembler`: byte shift-in, lane counter and full flag. Keeps the FSM file to control only.

Test Plan:
1. reset high for 1 cycle, then idle 5 cycles -> cpu_reset=1, rx_ready=0, im_we=0, done=0, error=0 throughout.
2. start; stream N=2, then 93 00 50 00 and 13 01 A0 00 with rx_valid always high (no checksum) -> writes 0x00500093 @0 and 0x00A00113 @1; im_we pulses exactly twice; done=1 and cpu_reset=0 one cycle after the second write.
3. Same image with rx_valid toggling every other cycle -> identical writes; no byte lost or duplicated.
4. N=33 (ADDR_W=5) -> ERROR next edge; error=1, no im_we, cpu_reset=1. Then start with N=1 -> recovers, loads word @0.
5. reset asserted after 6 data bytes of N=3 -> exactly one write (@0) observed; outputs at reset values next edge. A new start reloads from address 0.
6. BOOT_CHECKSUM_EN: N=1, bytes 93 00 50 00, then checksum C3 -> done=1. Same with checksum C2 -> error=1, cpu_reset stays 1.
